// File: rtl/mem_read_sched.sv
// Read sequencer for one output-stationary tile pass: walks M/N row blocks x M columns,
// then waits out the bank skew chain and the array drain before pulsing done.
module mem_read_sched #(
  parameter int N         = 3,
  parameter int M         = 6,
  parameter int DRAIN_CYC = 8,
  parameter int ROW_W     = (M / N > 1) ? $clog2(M / N) : 1,
  parameter int COL_W     = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stall,
  input  logic             abort,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] column,
  output logic             rd_en,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      stall_cnt
);

  localparam int CNT_MAX = (N > DRAIN_CYC) ? N : DRAIN_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(M / N - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(M - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    SKEW  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_nxt;
  logic [COL_W-1:0] col_nxt;
  logic             rd_en_nxt;
  logic             last_nxt;
  logic [15:0]      stall_cnt_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt     = state;
    row_nxt       = row;
    col_nxt       = column;
    rd_en_nxt     = 1'b0;
    cnt_nxt       = cnt;
    stall_cnt_nxt = stall_cnt;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt     = READ;
          row_nxt       = '0;
          col_nxt       = '0;
          rd_en_nxt     = 1'b1;
          stall_cnt_nxt = '0;
        end
      end

      READ: begin
        if (stall && (stall_cnt != 16'hFFFF))
          stall_cnt_nxt = stall_cnt + 16'd1;
        // The presented address counts as issued only when rd_en is high; after a
        // bubble the pending address is re-presented instead of advancing.
        if (rd_en && (row == ROW_LAST) && (column == COL_LAST)) begin
          row_nxt   = '0;
          col_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = (N > 1) ? SKEW : DRAIN;
        end else begin
          if (rd_en) begin
            if (column == COL_LAST) begin
              col_nxt = '0;
              row_nxt = row + 1'b1;
            end else begin
              col_nxt = column + 1'b1;
            end
          end
          rd_en_nxt = !stall;
        end
      end

      SKEW: begin
        if (int'(cnt) == N - 2) begin
          cnt_nxt   = '0;
          state_nxt = DRAIN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DRAIN: begin
        if (int'(cnt) == DRAIN_CYC - 1) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase

    // Abort wins over stall/start; the stall count of the cancelled pass is kept.
    if (abort && (state != IDLE)) begin
      state_nxt     = IDLE;
      row_nxt       = '0;
      col_nxt       = '0;
      rd_en_nxt     = 1'b0;
      cnt_nxt       = '0;
      stall_cnt_nxt = stall_cnt;
    end

    last_nxt = rd_en_nxt && (row_nxt == ROW_LAST) && (col_nxt == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row       <= '0;
      column    <= '0;
      rd_en     <= 1'b0;
      last      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      stall_cnt <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      row       <= row_nxt;
      column    <= col_nxt;
      rd_en     <= rd_en_nxt;
      last      <= last_nxt;
      busy      <= (state_nxt != IDLE);
      done      <= (state_nxt == DONE);
      stall_cnt <= stall_cnt_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule
